// File: rtl/fp_addsub_pipe_if.sv
// Handshake and operand/result bundle for the floating-point add/sub pipeline.
// The slave modport is the pipeline side and the master modport is the producer/consumer side.
interface fp_addsub_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  ovf;
  logic                  nan;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, ovf, nan
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, ovf, nan
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 style adder/subtractor.
//   S1 : unpack, classify specials, order operands by magnitude, align the smaller one
//   S2 : signed mantissa add/subtract
//   S3 : normalize, round to nearest even, pack (output register)
// Subnormal inputs and results are flushed to zero. A single global stall freezes
// every stage while a result waits for the consumer.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic             clk,
  input logic             rst_n,
  fp_addsub_pipe_if.slave bus
);

  localparam int DATA_WIDTH = 1 + EXP_W + MAN_W;
  // hidden bit + stored mantissa + guard/round/sticky
  localparam int W    = MAN_W + 4;
  localparam int LZ_W = $clog2(W + 1);
  // signed exponent working width, wide enough for exp - leading_zeros and exp + 2
  localparam int EW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic [EW-1:0]         EXP_MAX  = EW'(EXP_ONES);
  localparam logic [DATA_WIDTH-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall;
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // ---------------- stage 1 combinational ----------------
  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb, e_l, e_s, shamt;
  logic [MAN_W-1:0]      fa, fb;
  logic                  a_nan, b_nan, a_inf, b_inf;
  logic                  b_gt_a, s_l;
  logic [W-1:0]          m_a, m_b, m_l, m_s, lost, m_s_al;
  logic                  sp, sp_nan;
  logic [DATA_WIDTH-1:0] sp_val;

  // Unpack both operands, pick the larger magnitude first and align the other to it
  always_comb begin
    sa     = bus.a[DATA_WIDTH-1];
    sb     = bus.b[DATA_WIDTH-1] ^ bus.op;
    ea     = bus.a[DATA_WIDTH-2 -: EXP_W];
    eb     = bus.b[DATA_WIDTH-2 -: EXP_W];
    fa     = bus.a[MAN_W-1:0];
    fb     = bus.b[MAN_W-1:0];
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    // a zero exponent field means zero: the stored fraction is dropped with the hidden bit
    m_a    = (ea != '0) ? {1'b1, fa, 3'b000} : '0;
    m_b    = (eb != '0) ? {1'b1, fb, 3'b000} : '0;
    b_gt_a = {eb, fb} > {ea, fa};
    if (b_gt_a) begin
      e_l = eb;
      e_s = ea;
      m_l = m_b;
      m_s = m_a;
      s_l = sb;
    end else begin
      e_l = ea;
      e_s = eb;
      m_l = m_a;
      m_s = m_b;
      s_l = sa;
    end
    shamt  = e_l - e_s;
    // everything shifted past the LSB folds into the sticky position
    lost   = m_s & ~({W{1'b1}} << shamt);
    m_s_al = (m_s >> shamt) | {{(W-1){1'b0}}, |lost};
    sp     = a_nan | b_nan | a_inf | b_inf;
    sp_nan = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
    if (sp_nan)
      sp_val = QNAN;
    else if (a_inf)
      sp_val = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else
      sp_val = {sb, EXP_ONES, {MAN_W{1'b0}}};
  end

  logic                  v1, sp1, sp_nan1, sub1, sign1, zs1;
  logic [DATA_WIDTH-1:0] sp_val1;
  logic [EXP_W-1:0]      exp1;
  logic [W-1:0]          ml1, ms1;

  // Stage 1 register: ordered, aligned operands plus the special-case bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      sp1     <= 1'b0;
      sp_nan1 <= 1'b0;
      sp_val1 <= '0;
      sub1    <= 1'b0;
      sign1   <= 1'b0;
      zs1     <= 1'b0;
      exp1    <= '0;
      ml1     <= '0;
      ms1     <= '0;
    end else if (!stall) begin
      v1      <= bus.in_valid;
      sp1     <= sp;
      sp_nan1 <= sp_nan;
      sp_val1 <= sp_val;
      sub1    <= sa ^ sb;
      sign1   <= s_l;
      // a zero sum is negative only when both effective signs are negative
      zs1     <= sa & sb;
      exp1    <= e_l;
      ml1     <= m_l;
      ms1     <= m_s_al;
    end
  end

  // ---------------- stage 2 ----------------
  logic                  v2, sp2, sp_nan2, sign2, zs2;
  logic [DATA_WIDTH-1:0] sp_val2;
  logic [EXP_W-1:0]      exp2;
  logic [W:0]            sum2;

  // Stage 2 register: magnitude add or subtract (larger operand is always first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      sp2     <= 1'b0;
      sp_nan2 <= 1'b0;
      sp_val2 <= '0;
      sign2   <= 1'b0;
      zs2     <= 1'b0;
      exp2    <= '0;
      sum2    <= '0;
    end else if (!stall) begin
      v2      <= v1;
      sp2     <= sp1;
      sp_nan2 <= sp_nan1;
      sp_val2 <= sp_val1;
      sign2   <= sign1;
      zs2     <= zs1;
      exp2    <= exp1;
      sum2    <= sub1 ? ({1'b0, ml1} - {1'b0, ms1}) : ({1'b0, ml1} + {1'b0, ms1});
    end
  end

  // ---------------- stage 3 combinational ----------------
  logic [LZ_W-1:0]       lz;
  logic [W-1:0]          norm;
  logic [EW-1:0]         e_norm, e_rnd;
  logic                  round_up;
  logic [MAN_W:0]        frac_rnd;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_ovf, res_nan;

  // Normalize, round to nearest even and pack, or forward the special result
  always_comb begin
    lz = LZ_W'(W);
    for (int i = 0; i < W; i++)
      if (sum2[i]) lz = LZ_W'(W - 1 - i);
    if (sum2[W]) begin
      norm   = {sum2[W:2], sum2[1] | sum2[0]};
      e_norm = EW'(exp2) + EW'(1);
    end else begin
      norm   = sum2[W-1:0] << lz;
      e_norm = EW'(exp2) - EW'(lz);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    // a carry out of the fraction means 1.111..1 rounded up to 10.000..0
    frac_rnd = {1'b0, norm[W-2:3]} + {{MAN_W{1'b0}}, round_up};
    e_rnd    = e_norm + EW'(frac_rnd[MAN_W]);
    res_ovf  = 1'b0;
    res_nan  = 1'b0;
    if (sp2) begin
      res     = sp_val2;
      res_nan = sp_nan2;
    end else if (!norm[W-1]) begin
      res = {zs2, {(DATA_WIDTH-1){1'b0}}};
    end else if (e_norm[EW-1] || (e_norm == '0)) begin
      res = {sign2, {(DATA_WIDTH-1){1'b0}}};
    end else if (e_rnd >= EXP_MAX) begin
      res     = {sign2, EXP_ONES, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else begin
      res = {sign2, e_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    end
  end

  logic                  out_valid_q, ovf_q, nan_q;
  logic [DATA_WIDTH-1:0] out_q;

  // Output register: holds its value while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      nan_q       <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= v2;
      if (v2) begin
        out_q <= res;
        ovf_q <= res_ovf;
        nan_q <= res_nan;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;
  assign bus.nan       = nan_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed vectors, a stalled stream, reset mid-flight and
// a randomized stream scored against an exact-arithmetic reference model.
module tb_fp_addsub_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int DW    = 1 + EXP_W + MAN_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.DATA_WIDTH(DW)) bus ();

  fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic        nan;
    int          cyc_in;
    int          snap;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Exact reference: operands become wide integers scaled by 2^-149, are summed exactly,
  // then rounded to 24 significant bits (nearest, ties to even). Returns {nan, ovf, out}.
  function automatic logic [33:0] ref_addsub(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic         sa, sb, a_nan, b_nan, a_inf, b_inf, rs;
    int           ea, eb, p, e, sh;
    logic [319:0] va, vb, big, sml, s, q, rem, half;
    sa    = a[31];
    sb    = b[31] ^ op;
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return {2'b10, 32'h7FC00000};
    if (a_inf) return {2'b00, sa, 8'hFF, 23'h0};
    if (b_inf) return {2'b00, sb, 8'hFF, 23'h0};
    va = (ea == 0) ? 320'd0 : (320'({1'b1, a[22:0]}) << (ea - 1));
    vb = (eb == 0) ? 320'd0 : (320'({1'b1, b[22:0]}) << (eb - 1));
    if ((va == 0) && (vb == 0)) return {2'b00, sa & sb, 31'h0};
    if (vb > va) begin big = vb; sml = va; rs = sb; end
    else begin big = va; sml = vb; rs = sa; end
    s = (sa == sb) ? (big + sml) : (big - sml);
    if (s == 0) return 34'h0;
    p = 0;
    for (int i = 0; i < 320; i++) if (s[i]) p = i;
    e = p - 22;
    if (e <= 0) return {2'b00, rs, 31'h0};
    sh = p - 23;
    q  = s >> sh;
    if (sh > 0) begin
      rem  = s & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 320'd1;
    end
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {2'b01, rs, 8'hFF, 23'h0};
    return {2'b00, rs, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] pick_special(input int k);
    logic [31:0] r;
    case (k)
      0:       r = 32'h00000000;
      1:       r = 32'h80000000;
      2:       r = 32'h7F800000;
      3:       r = 32'hFF800000;
      4:       r = 32'h7FC00000 | 32'($urandom_range(0, 255));
      default: r = 32'h7F7FFFFF;
    endcase
    return r;
  endfunction

  // Biased random operands: close exponents, rounding edges, cancellation, specials, overflow
  task automatic gen(output logic [31:0] a, output logic [31:0] b, output logic op);
    int k;
    a  = $urandom;
    b  = $urandom;
    op = 1'($urandom_range(0, 1));
    k  = $urandom_range(0, 15);
    if (k < 6)        b[30:23] = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
    else if (k < 8)   b[30:23] = a[30:23] - 8'($urandom_range(23, 26));
    else if (k < 10)  b[30:0]  = a[30:0] ^ 31'($urandom_range(0, 7));
    else if (k == 10) a = pick_special($urandom_range(0, 5));
    else if (k == 11) b = pick_special($urandom_range(0, 5));
    else if (k == 12) b[30:23] = 8'h00;
    else if (k == 13) begin
      a[30:23] = 8'hFE;
      b[30:23] = 8'($urandom_range(250, 254));
    end
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] want_out, input logic want_ovf, input logic want_nan);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.out_ready = 1'b1;
    #1 check_val("dir_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    #1;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("dir_latency", n, 3);
    check_val("dir_out", bus.out, want_out);
    check_val("dir_ovf", bus.ovf, want_ovf);
    check_val("dir_nan", bus.nan, want_nan);
  endtask

  // stall_window=1: back-to-back adds with out_ready low on cycles 4..6
  // stall_window=0: random operands, random input gaps, random out_ready
  task automatic run_stream(input int n_txn, input bit stall_window);
    int          sent, cyc, stall_cnt;
    logic        hold, prev_stall, stall_now;
    logic [31:0] a, b, held_out;
    logic        op, held_ovf, held_nan;
    logic [33:0] r;
    exp_t        e;
    sent = 0; cyc = 0; stall_cnt = 0;
    hold = 1'b0; prev_stall = 1'b0;
    held_out = '0; held_ovf = 1'b0; held_nan = 1'b0;
    a = '0; b = '0; op = 1'b0;
    while ((sent < n_txn || sb_q.size() != 0) && cyc < 20 * n_txn + 50) begin
      @(negedge clk);
      if (!hold) begin
        if (sent < n_txn && (stall_window || $urandom_range(0, 3) != 0)) begin
          if (stall_window) begin
            a  = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
            b  = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
            op = 1'b0;
          end else begin
            gen(a, b, op);
          end
          bus.a = a; bus.b = b; bus.op = op;
          bus.in_valid = 1'b1;
          hold = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = stall_window ? !(cyc >= 4 && cyc <= 6) : ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid) begin
        if (prev_stall) begin
          check_val("hold_out", bus.out, held_out);
          check_val("hold_ovf", bus.ovf, held_ovf);
          check_val("hold_nan", bus.nan, held_nan);
        end else begin
          check_val("result_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            check_val("latency", cyc - sb_q[0].cyc_in, 3 + stall_cnt - sb_q[0].snap);
            check_val("out", bus.out, sb_q[0].out);
            check_val("ovf", bus.ovf, sb_q[0].ovf);
            check_val("nan", bus.nan, sb_q[0].nan);
          end
        end
        if (bus.out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      end
      stall_now = bus.out_valid && !bus.out_ready;
      check_val("in_ready", bus.in_ready, !stall_now);
      if (stall_now) stall_cnt++;
      if (bus.in_valid && bus.in_ready) begin
        r        = ref_addsub(a, b, op);
        e.out    = r[31:0];
        e.ovf    = r[32];
        e.nan    = r[33];
        e.cyc_in = cyc;
        e.snap   = stall_cnt;
        sb_q.push_back(e);
        sent++;
        hold = 1'b0;
      end
      held_out   = bus.out;
      held_ovf   = bus.ovf;
      held_nan   = bus.nan;
      prev_stall = stall_now;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_val("stream_sent", sent, n_txn);
    check_val("stream_drained", sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    check_val("reset_out_valid", bus.out_valid, 0);
    check_val("reset_out", bus.out, 0);
    check_val("reset_ovf", bus.ovf, 0);
    check_val("reset_nan", bus.nan, 0);
    check_val("reset_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    directed(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
    directed(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    directed(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    directed(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    directed(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
    directed(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    directed(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
    directed(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
    directed(32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
    directed(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
    directed(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    directed(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
    directed(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
    directed(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
    directed(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    directed(32'h40000000, 32'h3FFFFFFF, 1'b1, 32'h34000000, 1'b0, 1'b0);

    run_stream(8, 1'b1);

    // reset with one result held at the output and two more in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0;
    @(negedge clk);
    bus.a = 32'h40400000;
    @(negedge clk);
    bus.a = 32'h40800000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_val("rst_pre_out_valid", bus.out_valid, 1);
    check_val("rst_pre_out", bus.out, 32'h40400000);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out", bus.out, 0);
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_ovf", bus.ovf, 0);
    check_val("rst_nan", bus.nan, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 check_val("rst_no_stale", bus.out_valid, 0);
    end
    directed(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0);

    run_stream(400, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width.
REQ-003 Parameter DATA_WIDTH, default 1+EXP_W+MAN_W (32), operand/result width, derived, never overridden independently.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand pair and op valid this cycle.
REQ-007 in_ready  output  1  pipeline accepts a transaction this cycle.
REQ-008 a  input  DATA_WIDTH  operand A, IEEE-754 layout {sign, exp, man}.
REQ-009 b  input  DATA_WIDTH  operand B, same layout.
REQ-010 op  input  1  0 = a+b, 1 = a-b.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out  output  DATA_WIDTH  result.
REQ-014 ovf  output  1  result overflowed to infinity; qualified by out_valid.
REQ-015 nan  output  1  result is NaN; qualified by out_valid.

Function
REQ-016 Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
REQ-017 Three registered stages: S1 unpack/swap/align, S2 signed mantissa add, S3 normalize/round/pack; latency exactly 3 clk from input transfer to out_valid with no stall.
REQ-018 Global stall: stall = out_valid && !out_ready; while stall all stages hold, in_ready = 0.
REQ-019 in_ready = !stall, combinational; one result per cycle sustained throughput when out_ready = 1.
REQ-020 Bubbles propagate: a stage's valid bit clears when fed no transfer; out and flags hold stable while out_valid && !out_ready.
REQ-021 Effective B sign = b sign XOR op; effective operation is subtract when A sign differs from effective B sign.
REQ-022 S1 swaps so larger magnitude is first (compare {exp,man}); tie keeps A first.
REQ-023 Hidden bit 1 for exp != 0; exp = 0 treated as zero (subnormal inputs flushed to zero, sign kept).
REQ-024 Alignment shift right by exponent difference with guard, round, sticky bits; shift >= MAN_W+3 leaves only sticky.
REQ-025 Result sign = sign of larger-magnitude operand; exact cancellation gives +0.
REQ-026 S3 normalizes: carry-out shifts right 1 and increments exponent; otherwise leading-zero count shifts left and decrements exponent.
REQ-027 Rounding: round-to-nearest, ties-to-even; mantissa round carry renormalizes.
REQ-028 Exponent >= 2^EXP_W-1 after rounding: out = signed infinity, ovf = 1.
REQ-029 Exponent <= 0 after normalization: out = signed zero (flush), ovf = 0.
REQ-030 Special cases bypass arithmetic, same latency: any NaN input, or inf minus inf, gives canonical quiet NaN {0, all-ones exp, 1 then zeros}, nan = 1; single inf gives that inf; inf plus same-sign inf gives that inf, ovf = 0.
REQ-031 Zero plus zero: +0 unless both effective signs negative, then -0.

Reset
REQ-032 While rst_n = 0: all stage valid bits, out_valid, ovf, nan = 0; out = 0; in_ready = 1 once stall clears (stall = 0 in reset).
REQ-033 Reset mid-operation discards all in-flight transactions; no output after release until a new input transfer plus 3 clk.
REQ-034 Deassertion takes effect on the next rising clk; first transfer may occur that edge.

Verification
REQ-035 a=0x3F800000, b=0x40000000, op=0, out_ready=1 -> 3 clk later out=0x40400000, ovf=0, nan=0.
REQ-036 a=0x3F800000, b=0x3F800000, op=1 -> out=0x00000000; a=0x40400000, b=0xBF800000, op=0 -> out=0x40000000.
REQ-037 a=b=0x7F7FFFFF, op=0 -> out=0x7F800000, ovf=1; a=0x7F800000, b=0xFF800000, op=0 -> out=0x7FC00000, nan=1.
REQ-038 Stream 8 back-to-back adds, out_ready=0 for cycles 4-6 -> in_ready=0 during stall, out held stable, all 8 results in order, none lost or duplicated.
REQ-039 Assert rst_n=0 with 2 transactions in flight -> out_valid=0 immediately, no stale result after release.
REQ-040 a=0x3F800000, b=0x33800000 (2^-24), op=0 -> tie rounds to even, out=0x3F800000; b=0x33800001 -> out=0x3F800001.
